// File: rtl/muladd_pkg.sv
// Shared types and constants for muladd_reconstruct: FSM state encoding,
// default operand sizing, and msb_index (used by the bench to predict early-exit latency).
package muladd_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the highest set bit; 0 for a zero operand.
  function automatic int msb_index(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/muladd_reconstruct.sv
// Sequential radix-2 shift-add: product = quotient * divisor + remainder.
// Build option MULADD_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module muladd_reconstruct
  import muladd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   dividend,
  output logic               overflow,
  output logic               rem_invalid
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rinv_q, rinv_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 ovf_q, ovf_d;
  logic                 rem_invalid_q, rem_invalid_d;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    cnt_d         = cnt_q;
    rinv_d        = rinv_q;
    done_d        = 1'b0;
    product_d     = product_q;
    ovf_d         = ovf_q;
    rem_invalid_d = rem_invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = {{WIDTH{1'b0}}, remainder};
          mcand_d  = {{WIDTH{1'b0}}, divisor};
          mplier_d = quotient;
          cnt_d    = '0;
          rinv_d   = (remainder >= divisor);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULADD_EARLY_EXIT_EN
        // Once no multiplier bits remain, later steps would add nothing.
        if ((mplier_d == '0) || (cnt_q == LAST_CNT)) state_d = ST_DONE;
`else
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        done_d        = 1'b1;
        product_d     = acc_q;
        ovf_d         = |acc_q[2*WIDTH-1:WIDTH];
        rem_invalid_d = rinv_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
      rinv_q        <= 1'b0;
      done_q        <= 1'b0;
      product_q     <= '0;
      ovf_q         <= 1'b0;
      rem_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      cnt_q         <= cnt_d;
      rinv_q        <= rinv_d;
      done_q        <= done_d;
      product_q     <= product_d;
      ovf_q         <= ovf_d;
      rem_invalid_q <= rem_invalid_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign product     = product_q;
  assign dividend    = product_q[WIDTH-1:0];
  assign overflow    = ovf_q;
  assign rem_invalid = rem_invalid_q;

endmodule

// File: tb/tb_muladd_reconstruct.sv
// Scoreboard bench for muladd_reconstruct: directed triples, held start,
// mid-run reset abort, and divider round-trips through a behavioural quotient/remainder model.
module tb_muladd_reconstruct;
  import muladd_pkg::*;

  localparam int W = DEF_WIDTH;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   quotient = '0;
  logic [W-1:0]   divisor = '0;
  logic [W-1:0]   remainder = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   dividend;
  logic           overflow;
  logic           rem_invalid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           ovf;
    logic           rinv;
    int             k;
    int             lat;
  } exp_t;

  exp_t exp_q[$];

  muladd_reconstruct #(.WIDTH(W), .CNT_W(DEF_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .busy(busy), .done(done), .product(product), .dividend(dividend),
    .overflow(overflow), .rem_invalid(rem_invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Start edge to the edge where done is first seen high: one accept edge, n RUN edges, one DONE edge.
  function automatic int exp_lat(input logic [W-1:0] q);
    int n;
`ifdef MULADD_EARLY_EXIT_EN
    n = msb_index({{W{1'b0}}, q}) + 1;
`else
    n = W;
`endif
    return n + 2;
  endfunction

  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r,
                       input bit push, input logic [2*W-1:0] eprod, input logic eovf,
                       input logic erinv);
    int g;
    exp_t e;
    @(negedge clk);
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("idle_timeout", busy, 0);
    start = 1'b1;
    quotient = q;
    divisor = b;
    remainder = r;
    if (push) begin
      e.prod = eprod; e.ovf = eovf; e.rinv = erinv; e.k = cyc + 1; e.lat = exp_lat(q);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    quotient = $urandom;
    divisor = $urandom;
    remainder = $urandom;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", product, e.prod);
        check("dividend", dividend, e.prod[W-1:0]);
        check("overflow", overflow, e.ovf);
        check("rem_invalid", rem_invalid, e.rinv);
        check("latency", cyc + 1 - e.k, e.lat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_run, max_gap, g;
    bit seen;
    logic [W-1:0] a, b;
    exp_t e;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rem_invalid", rem_invalid, 0);
    rst_n = 1'b1;

    issue(32'd7, 32'd3, 32'd2, 1, 64'd23, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 64'hFFFF_FFFE_FFFF_FFFF, 1'b1, 1'b0);
    issue(32'd9, 32'd0, 32'd5, 1, 64'd5, 1'b0, 1'b1);
    issue(32'd4, 32'd4, 32'd4, 1, 64'd20, 1'b0, 1'b1);
    issue(32'd0, 32'd17, 32'd3, 1, 64'd3, 1'b0, 1'b0);

    // Held start: every IDLE cycle relaunches; 5*6+1 = 31.
    @(negedge clk);
    g = 0;
    while (busy && g < 200) begin @(negedge clk); g++; end
    start = 1'b1;
    quotient = 32'd5; divisor = 32'd6; remainder = 32'd1;
    low_run = 0; max_gap = 0; seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin
        e.prod = 64'd31; e.ovf = 1'b0; e.rinv = 1'b0; e.k = cyc + 1; e.lat = exp_lat(32'd5);
        exp_q.push_back(e);
        if (seen) begin
          low_run++;
          if (low_run > max_gap) max_gap = low_run;
        end
        seen = 1;
      end else begin
        low_run = 0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_gap_max", max_gap, 1);

    // Mid-run reset abort: no result may appear for this job.
    issue(32'hFFFF_FFFF, 32'd3, 32'd1, 0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(32'd12, 32'd10, 32'd3, 1, 64'd123, 1'b0, 1'b0);

    // Divider round-trip: the triple from a/b, a%b must rebuild a exactly.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom) : W'($urandom_range(1, 1000));
      if (b == '0) b = 1;
      issue(a / b, b, a % b, 1, {{W{1'b0}}, a}, 1'b0, 1'b0);
    end

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin @(negedge clk); g++; end
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
